// File: rtl/oam_dma_arbiter_mod_if.sv
// CPU-side and external memory bus bundle for the OAM DMA arbiter.
// master = CPU/memory side driving requests, slave = the arbiter.
interface oam_dma_arbiter_mod_if;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_rd;
   logic        cpu_wr;
   logic [7:0]  cpu_rdata;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [7:0]  mem_rdata;
   logic        dma_active;

   modport master (
      output cpu_addr, cpu_wdata, cpu_rd, cpu_wr, mem_rdata,
      input  cpu_rdata, mem_addr, mem_wdata, mem_rd, mem_wr, dma_active
   );

   modport slave (
      input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr, mem_rdata,
      output cpu_rdata, mem_addr, mem_wdata, mem_rd, mem_wr, dma_active
   );
endinterface

// File: rtl/oam_dma_arbiter_mod.sv
// CPU/OAM-DMA bus arbiter with FF46 DMA register and HRAM; CPU path is combinational,
// DMA copies one byte per 2 clocks and locks the CPU out of everything except FF46/HRAM.
module oam_dma_arbiter_mod #(
   parameter int unsigned DMA_LEN     = 160,
   parameter int unsigned START_DELAY = 4,
   parameter logic [15:0] OAM_BASE    = 16'hFE00
) (
   input logic            clock,
   input logic            reset,
   oam_dma_arbiter_mod_if.slave bus
);
   localparam int unsigned    DW         = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
   localparam logic [7:0]     LAST_IDX   = 8'(DMA_LEN - 1);
   localparam logic [DW-1:0]  DELAY_INIT = DW'(START_DELAY - 1);

   typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;

   state_t        state;
   logic [7:0]    src_hi;
   logic [7:0]    idx;
   logic [7:0]    dma_buf;
   logic [DW-1:0] delay;
   logic          dma_active_q;
   logic [7:0]    hram [0:126];

   logic       is_dma_reg;
   logic       is_hram;
   logic       dma_bus;
   logic       restart;
   logic [7:0] src_fold;

   assign is_dma_reg = (bus.cpu_addr == 16'hFF46);
   assign is_hram    = (bus.cpu_addr[15:7] == 9'h1FF) && (bus.cpu_addr[6:0] != 7'h7F);
   assign dma_bus    = (state == READ) || (state == WRITE);
   assign restart    = bus.cpu_wr && is_dma_reg;
   // Sources in the E0-FF range alias onto C0-DF (echo RAM fold).
   assign src_fold   = (bus.cpu_wdata >= 8'hE0) ? (bus.cpu_wdata & 8'hDF) : bus.cpu_wdata;

   assign bus.dma_active = dma_active_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         src_hi       <= 8'h00;
         idx          <= 8'h00;
         dma_buf      <= 8'h00;
         delay        <= '0;
         dma_active_q <= 1'b0;
      end else if (restart) begin
         state        <= START;
         src_hi       <= src_fold;
         idx          <= 8'h00;
         delay        <= DELAY_INIT;
         dma_active_q <= 1'b0;
      end else begin
         case (state)
            IDLE: ;
            START: begin
               if (delay == '0) begin
                  state        <= READ;
                  dma_active_q <= 1'b1;
               end else begin
                  delay <= delay - 1'b1;
               end
            end
            READ: begin
               dma_buf <= bus.mem_rdata;
               state   <= WRITE;
            end
            WRITE: begin
               if (idx == LAST_IDX) begin
                  idx          <= 8'h00;
                  state        <= IDLE;
                  dma_active_q <= 1'b0;
               end else begin
                  idx   <= idx + 8'h01;
                  state <= READ;
               end
            end
            default: begin
               state        <= IDLE;
               dma_active_q <= 1'b0;
            end
         endcase
      end
   end

   // HRAM has no reset; it is reachable from the CPU in every state.
   always_ff @(posedge clock) begin
      if (bus.cpu_wr && is_hram) begin
         hram[bus.cpu_addr[6:0]] <= bus.cpu_wdata;
      end
   end

   always_comb begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
      bus.mem_rd    = 1'b0;
      bus.mem_wr    = 1'b0;
      case (state)
         READ: begin
            bus.mem_addr = {src_hi, idx};
            bus.mem_rd   = 1'b1;
         end
         WRITE: begin
            bus.mem_addr  = OAM_BASE + {8'h00, idx};
            bus.mem_wdata = dma_buf;
            bus.mem_wr    = 1'b1;
         end
         default: begin
            if (!is_dma_reg && !is_hram) begin
               bus.mem_rd = bus.cpu_rd && !bus.cpu_wr;
               bus.mem_wr = bus.cpu_wr;
            end
         end
      endcase
   end

   always_comb begin
      if (is_dma_reg) begin
         bus.cpu_rdata = src_hi;
      end else if (is_hram) begin
         bus.cpu_rdata = hram[bus.cpu_addr[6:0]];
      end else if (dma_bus) begin
         bus.cpu_rdata = 8'hFF;
      end else begin
         bus.cpu_rdata = bus.mem_rdata;
      end
   end
endmodule

// File: tb/tb_oam_dma_arbiter_mod.sv
// Bench for oam_dma_arbiter_mod: flat 64K memory, cycle-count model of the DMA timeline,
// directed scenarios plus a randomized CPU traffic run.
module tb_oam_dma_arbiter_mod;
   localparam int SD  = 4;
   localparam int LEN = 160;

   logic clock;
   logic reset;
   oam_dma_arbiter_mod_if bus ();

   oam_dma_arbiter_mod #(.DMA_LEN(LEN), .START_DELAY(SD), .OAM_BASE(16'hFE00)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [7:0] ext_mem [0:65535];
   assign bus.mem_rdata = ext_mem[bus.mem_addr];

   int n_cmp = 0;
   int n_bad = 0;

   // Model: DMA is a timeline of cycles since the FF46 write edge.
   bit         m_on;
   int         m_t;
   logic [7:0] m_src;
   logic [7:0] m_buf;
   logic [7:0] m_hram [0:127];
   bit         m_hv   [0:127];

   int          cnt_wr, cnt_act;
   logic [7:0]  last_rdata;
   logic        last_mrd, last_mwr;
   logic [15:0] last_maddr;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic rd, input logic wr);
      bit in_rd, in_wr, is46, ish, known;
      int k, byt;
      logic [15:0] ea;
      logic [7:0]  ew, er;
      logic        erd, ewr;
      logic        dwr;
      logic [15:0] dwa;
      logic [7:0]  dwd;
      bus.cpu_addr  = a;
      bus.cpu_wdata = d;
      bus.cpu_rd    = rd;
      bus.cpu_wr    = wr;
      #2;
      in_rd = 0; in_wr = 0; byt = 0;
      if (m_on && m_t > SD) begin
         k     = m_t - SD - 1;
         byt   = k / 2;
         in_rd = (k % 2) == 0;
         in_wr = !in_rd;
      end
      is46 = (a == 16'hFF46);
      ish  = (a >= 16'hFF80) && (a <= 16'hFFFE);
      if (in_rd) begin
         ea = {m_src, 8'(byt)}; erd = 1; ewr = 0; ew = 0;
      end else if (in_wr) begin
         ea = 16'hFE00 + 16'(byt); erd = 0; ewr = 1; ew = m_buf;
      end else begin
         ea  = a;
         erd = !is46 && !ish && rd && !wr;
         ewr = !is46 && !ish && wr;
         ew  = d;
      end
      known = 1;
      if (is46) er = m_src;
      else if (ish) begin known = m_hv[a[6:0]]; er = m_hram[a[6:0]]; end
      else if (in_rd || in_wr) er = 8'hFF;
      else er = ext_mem[a];

      chk("mem_addr", bus.mem_addr, ea);
      chk("mem_rd", 16'(bus.mem_rd), 16'(erd));
      chk("mem_wr", 16'(bus.mem_wr), 16'(ewr));
      if (ewr) chk("mem_wdata", 16'(bus.mem_wdata), 16'(ew));
      chk("dma_active", 16'(bus.dma_active), 16'(in_rd || in_wr));
      if (known) chk("cpu_rdata", 16'(bus.cpu_rdata), 16'(er));

      last_rdata = bus.cpu_rdata;
      last_mrd   = bus.mem_rd;
      last_mwr   = bus.mem_wr;
      last_maddr = bus.mem_addr;
      cnt_wr  += int'(bus.mem_wr);
      cnt_act += int'(bus.dma_active);
      dwr = bus.mem_wr; dwa = bus.mem_addr; dwd = bus.mem_wdata;

      if (wr && is46) begin
         m_src = (d >= 8'hE0) ? (d & 8'hDF) : d;
         m_on  = 1;
         m_t   = 1;
      end else if (m_on) begin
         if (in_rd) m_buf = ext_mem[ea];
         if (m_t == SD + 2 * LEN) m_on = 0;
         else m_t++;
      end
      if (wr && ish) begin
         m_hram[a[6:0]] = d;
         m_hv[a[6:0]]   = 1;
      end
      @(posedge clock);
      if (dwr) ext_mem[dwa] = dwd;
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(16'h0000, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      bus.cpu_addr  = 16'hFF46;
      bus.cpu_wdata = 8'h00;
      bus.cpu_rd    = 1'b1;
      bus.cpu_wr    = 1'b0;
      reset = 1'b0;
      #2;
      chk("rst_dma_active", 16'(bus.dma_active), 16'h0);
      chk("rst_mem_rd", 16'(bus.mem_rd), 16'h0);
      chk("rst_mem_wr", 16'(bus.mem_wr), 16'h0);
      chk("rst_ff46", 16'(bus.cpu_rdata), 16'h00);
      chk("rst_mem_addr", bus.mem_addr, 16'hFF46);
      m_on = 0; m_t = 0; m_src = 8'h00; m_buf = 8'h00;
      @(posedge clock);
      #1 reset = 1'b1;
   endtask

   task automatic check_oam(input string nm, input logic [7:0] x);
      int bad;
      bad = 0;
      for (int i = 0; i < LEN; i++) begin
         logic [7:0] e;
         e = 8'(i) ^ x;
         if (ext_mem[16'hFE00 + 16'(i)] !== e) bad++;
      end
      chk(nm, 16'(bad), 16'h0);
   endtask

   initial begin
      for (int i = 0; i < 128; i++) m_hv[i] = 0;
      for (int i = 0; i < 65536; i++) ext_mem[i] = 8'($urandom);
      for (int i = 0; i < LEN; i++) begin
         ext_mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'h5A;
         ext_mem[16'hC300 + 16'(i)] = 8'(i) ^ 8'hA5;
         ext_mem[16'hD200 + 16'(i)] = 8'(i) ^ 8'h3C;
      end
      do_reset();

      // Pass-through: write wins over read; FF46 never reaches the bus.
      cyc(16'h8000, 8'hAB, 1'b1, 1'b1);
      chk("pt_rdwr_mem_wr", 16'(last_mwr), 16'h1);
      chk("pt_rdwr_mem_rd", 16'(last_mrd), 16'h0);
      cyc(16'h4000, 8'h00, 1'b1, 1'b0);
      cyc(16'hFF46, 8'hC1, 1'b0, 1'b1);
      chk("ff46_not_forwarded", 16'(last_mwr), 16'h0);

      // Full copy from C1: the start cycle above opened the timeline.
      cnt_wr = 0; cnt_act = 0;
      idle(SD + 2 * LEN);
      chk("c1_wr_pulses", 16'(cnt_wr), 16'(LEN));
      chk("c1_active_clks", 16'(cnt_act), 16'(2 * LEN));
      check_oam("oam_c1", 8'h5A);
      idle(2);

      // CPU lockout during DMA, HRAM still usable.
      ext_mem[16'hD000] = 8'h11;
      cyc(16'hFF46, 8'hC1, 1'b0, 1'b1);
      idle(10);
      cyc(16'hC000, 8'h00, 1'b1, 1'b0);
      chk("lock_c000_rdata", 16'(last_rdata), 16'h00FF);
      chk("lock_c000_not_on_bus", 16'(last_maddr == 16'hC000), 16'h0);
      cyc(16'hFF90, 8'h3C, 1'b0, 1'b1);
      cyc(16'hFF90, 8'h00, 1'b1, 1'b0);
      chk("lock_hram_rd", 16'(last_rdata), 16'h003C);
      cyc(16'hD000, 8'h77, 1'b0, 1'b1);
      idle(2 * LEN);
      chk("lock_d000_dropped", 16'(ext_mem[16'hD000]), 16'h0011);

      // Echo fold: F2 -> D2.
      cyc(16'hFF46, 8'hF2, 1'b0, 1'b1);
      cyc(16'hFF46, 8'h00, 1'b1, 1'b0);
      chk("fold_ff46_rd", 16'(last_rdata), 16'h00D2);
      idle(SD + 2 * LEN);
      check_oam("oam_d2", 8'h3C);

      // Restart at byte 10 (READ phase) from C1 to C3.
      cyc(16'hFF46, 8'hC1, 1'b0, 1'b1);
      idle(SD + 20);
      cnt_wr = 0;
      cyc(16'hFF46, 8'hC3, 1'b0, 1'b1);
      chk("restart_no_wr", 16'(cnt_wr), 16'h0);
      idle(SD + 2 * LEN);
      chk("restart_wr_pulses", 16'(cnt_wr), 16'(LEN));
      check_oam("oam_c3", 8'hA5);

      // Reset in the middle of a transfer, around byte 50.
      cyc(16'hFF46, 8'hC1, 1'b0, 1'b1);
      idle(SD + 100);
      do_reset();
      cyc(16'h9000, 8'h00, 1'b1, 1'b0);
      chk("post_rst_pt_rd", 16'(last_mrd), 16'h1);

      // Random CPU traffic with occasional restarts.
      for (int n = 0; n < 4000; n++) begin
         int r;
         logic [15:0] a;
         logic rd, wr;
         r = $urandom_range(999);
         if (r < 3) a = 16'hFF46;
         else if (r < 200) a = {9'h1FF, 7'($urandom)};
         else if (r < 260) a = 16'hFE00 + 16'($urandom_range(LEN - 1));
         else a = 16'($urandom);
         rd = 1'($urandom);
         wr = (a == 16'hFF46) ? 1'b1 : ($urandom_range(2) == 0);
         cyc(a, 8'($urandom), rd, wr);
      end
      idle(SD + 2 * LEN + 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
